// File: rtl/cp0_nlane.sv
// cp0_nlane: commit-stage CP0 for an N-issue MIPS pipeline; picks the oldest event across lanes.
// Count/Compare timer is built only when CP0_TIMER_EN is defined.
module cp0_nlane #(
    parameter int unsigned LANES     = 2,
    parameter int unsigned HW_INT    = 6,
    parameter logic [31:0] EXC_VEC   = 32'hBFC0_0380,
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANES-1:0]      lane_valid_i,
    input  logic [LANES*7-1:0]    lane_exc_i,
    input  logic [LANES-1:0]      lane_eret_i,
    input  logic [LANES-1:0]      lane_bd_i,
    input  logic [LANES*32-1:0]   lane_pc_i,
    input  logic [LANES*32-1:0]   lane_badaddr_i,
    input  logic                  cp0_we_i,
    input  logic [4:0]            cp0_waddr_i,
    input  logic [31:0]           cp0_wdata_i,
    input  logic [4:0]            cp0_raddr_i,
    output logic [31:0]           cp0_rdata_o,
    input  logic [HW_INT-1:0]     hw_int_i,
    output logic                  flush_o,
    output logic [31:0]           flush_pc_o,
    output logic [LANES-1:0]      kill_o,
    output logic                  int_pending_o
);

    localparam logic [4:0] RegBadVAddr = 5'd8;
    localparam logic [4:0] RegCount    = 5'd9;
    localparam logic [4:0] RegCompare  = 5'd11;
    localparam logic [4:0] RegStatus   = 5'd12;
    localparam logic [4:0] RegCause    = 5'd13;
    localparam logic [4:0] RegEpc      = 5'd14;

    localparam logic [4:0] ExcInt  = 5'd0;
    localparam logic [4:0] ExcAdel = 5'd4;
    localparam logic [4:0] ExcAdes = 5'd5;
    localparam logic [4:0] ExcSys  = 5'd8;
    localparam logic [4:0] ExcBp   = 5'd9;
    localparam logic [4:0] ExcRi   = 5'd10;
    localparam logic [4:0] ExcOv   = 5'd12;

    localparam logic [31:0] StatusRst = 32'h0040_0000;
    localparam int unsigned StBev     = 22;
    localparam int unsigned StExl     = 1;
    localparam int unsigned StIe      = 0;
    localparam int unsigned IdxW      = (LANES > 1) ? $clog2(LANES) : 1;

    if (COUNT_DIV < 1) begin : g_div_chk
        $error("COUNT_DIV must be at least 1");
    end

    logic [31:0] status_q, status_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        cause_bd_q, cause_bd_d;
    logic [1:0]  cause_ip_sw_q, cause_ip_sw_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [5:0]  hw_ip_q, hw_ip_d;
    logic        int_pending_q, int_pending_d;

    logic [31:0] timer_count;
    logic [31:0] timer_compare;
    logic        timer_ti;

    logic [7:0]  cause_ip;
    logic [31:0] cause_word;

    // ---------------------------------------------------------------- event selection
    logic            ev_valid;
    logic            ev_exc;
    logic            ev_bd;
    logic            ev_bva_we;
    logic [IdxW-1:0] ev_lane;
    logic [4:0]      ev_code;
    logic [31:0]     ev_pc;
    logic [31:0]     ev_bva;
    logic [6:0]      fl;

    always_comb begin
        ev_valid  = 1'b0;
        ev_exc    = 1'b0;
        ev_bd     = 1'b0;
        ev_bva_we = 1'b0;
        ev_lane   = '0;
        ev_code   = ExcInt;
        ev_pc     = '0;
        ev_bva    = '0;
        fl        = '0;
        if (int_pending_q && lane_valid_i[0]) begin
            // A pending interrupt rides on lane 0 and outranks every lane event.
            ev_valid = 1'b1;
            ev_exc   = 1'b1;
            ev_bd    = lane_bd_i[0];
            ev_pc    = lane_pc_i[31:0];
        end else begin
            for (int i = 0; i < LANES; i++) begin
                fl = lane_exc_i[i*7 +: 7];
                if (!ev_valid && lane_valid_i[i] && ((|fl) || lane_eret_i[i])) begin
                    ev_valid = 1'b1;
                    ev_exc   = |fl;
                    ev_lane  = IdxW'(i);
                    ev_bd    = lane_bd_i[i];
                    ev_pc    = lane_pc_i[i*32 +: 32];
                    if (fl[6]) begin
                        ev_code   = ExcAdel;
                        ev_bva_we = 1'b1;
                        ev_bva    = lane_pc_i[i*32 +: 32];
                    end else if (fl[5]) begin
                        ev_code = ExcRi;
                    end else if (fl[4]) begin
                        ev_code = ExcOv;
                    end else if (fl[3]) begin
                        ev_code = ExcSys;
                    end else if (fl[2]) begin
                        ev_code = ExcBp;
                    end else if (fl[1]) begin
                        ev_code   = ExcAdel;
                        ev_bva_we = 1'b1;
                        ev_bva    = lane_badaddr_i[i*32 +: 32];
                    end else if (fl[0]) begin
                        ev_code   = ExcAdes;
                        ev_bva_we = 1'b1;
                        ev_bva    = lane_badaddr_i[i*32 +: 32];
                    end
                end
            end
        end
    end

    logic exc_take;
    logic eret_take;
    logic mtc0_en;

    assign exc_take  = ev_valid && ev_exc;
    assign eret_take = ev_valid && !ev_exc;
    assign mtc0_en   = cp0_we_i && !(exc_take && (ev_lane == '0));

    assign flush_o       = ev_valid;
    assign flush_pc_o    = ev_exc ? EXC_VEC : epc_q;
    assign int_pending_o = int_pending_q;

    always_comb begin
        kill_o = '0;
        for (int j = 0; j < LANES; j++) begin
            if (ev_valid && ((IdxW'(j) > ev_lane) || ((IdxW'(j) == ev_lane) && ev_exc))) begin
                kill_o[j] = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- interrupt sampling
    always_comb begin
        hw_ip_d = '0;
        for (int k = 0; k < 6; k++) begin
            if (k < int'(HW_INT)) begin
                hw_ip_d[k] = hw_int_i[k % HW_INT];
            end
        end
    end

    assign cause_ip   = {hw_ip_q[5] | timer_ti, hw_ip_q[4:0], cause_ip_sw_q};
    assign cause_word = {cause_bd_q, timer_ti, 14'b0, cause_ip, 1'b0, exccode_q, 2'b00};

    // Suppressed while an exception is being taken so the same request is not re-taken
    // in the cycle before EXL becomes visible.
    assign int_pending_d = (|(cause_ip & status_q[15:8])) && status_q[StIe] &&
                           !status_q[StExl] && !exc_take;

    // ---------------------------------------------------------------- register next-state
    always_comb begin
        status_d      = status_q;
        epc_d         = epc_q;
        badvaddr_d    = badvaddr_q;
        cause_bd_d    = cause_bd_q;
        cause_ip_sw_d = cause_ip_sw_q;
        exccode_d     = exccode_q;

        if (mtc0_en) begin
            case (cp0_waddr_i)
                RegStatus: begin
                    status_d        = cp0_wdata_i;
                    status_d[StBev] = 1'b1;
                end
                RegCause: cause_ip_sw_d = cp0_wdata_i[9:8];
                RegEpc:   epc_d         = cp0_wdata_i;
                default:  ;
            endcase
        end

        // Hardware updates are applied last so they win over a same-cycle MTC0.
        if (exc_take) begin
            if (!status_q[StExl]) begin
                epc_d      = ev_bd ? (ev_pc - 32'd4) : ev_pc;
                cause_bd_d = ev_bd;
            end
            exccode_d       = ev_code;
            status_d[StExl] = 1'b1;
            if (ev_bva_we) begin
                badvaddr_d = ev_bva;
            end
        end else if (eret_take) begin
            status_d[StExl] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q      <= StatusRst;
            epc_q         <= '0;
            badvaddr_q    <= '0;
            cause_bd_q    <= 1'b0;
            cause_ip_sw_q <= '0;
            exccode_q     <= '0;
            hw_ip_q       <= '0;
            int_pending_q <= 1'b0;
        end else begin
            status_q      <= status_d;
            epc_q         <= epc_d;
            badvaddr_q    <= badvaddr_d;
            cause_bd_q    <= cause_bd_d;
            cause_ip_sw_q <= cause_ip_sw_d;
            exccode_q     <= exccode_d;
            hw_ip_q       <= hw_ip_d;
            int_pending_q <= int_pending_d;
        end
    end

    // ---------------------------------------------------------------- optional timer
`ifdef CP0_TIMER_EN
    localparam int unsigned PreW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [PreW-1:0] presc_q, presc_d;
    logic [31:0]     count_q, count_d;
    logic [31:0]     compare_q, compare_d;
    logic            ti_q, ti_d;

    always_comb begin
        presc_d   = presc_q + 1'b1;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (presc_q == PreW'(COUNT_DIV - 1)) begin
            presc_d = '0;
            count_d = count_q + 32'd1;
        end
        if (mtc0_en && (cp0_waddr_i == RegCount)) begin
            count_d = cp0_wdata_i;
            presc_d = '0;
        end
        if (mtc0_en && (cp0_waddr_i == RegCompare)) begin
            compare_d = cp0_wdata_i;
            ti_d      = 1'b0;
        end
        if ((count_q == compare_q) && (compare_q != '0)) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign timer_count   = count_q;
    assign timer_compare = compare_q;
    assign timer_ti      = ti_q;
`else
    assign timer_count   = '0;
    assign timer_compare = '0;
    assign timer_ti      = 1'b0;
`endif

    // ---------------------------------------------------------------- MFC0 read
    always_comb begin
        case (cp0_raddr_i)
            RegBadVAddr: cp0_rdata_o = badvaddr_q;
            RegCount:    cp0_rdata_o = timer_count;
            RegCompare:  cp0_rdata_o = timer_compare;
            RegStatus:   cp0_rdata_o = status_q;
            RegCause:    cp0_rdata_o = cause_word;
            RegEpc:      cp0_rdata_o = epc_q;
            default:     cp0_rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_nlane.sv
// Bench for cp0_nlane: directed scenarios followed by random commits against a behavioural model.
// Timer scenarios are included when CP0_TIMER_EN is defined.
module tb_cp0_nlane;

    localparam int          LANES = 2;
    localparam int          HW    = 6;
    localparam int          DIV   = 2;
    localparam logic [31:0] VEC   = 32'hBFC0_0380;
`ifdef CP0_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [LANES-1:0]    lane_valid;
    logic [LANES*7-1:0]  lane_exc;
    logic [LANES-1:0]    lane_eret;
    logic [LANES-1:0]    lane_bd;
    logic [LANES*32-1:0] lane_pc;
    logic [LANES*32-1:0] lane_badaddr;
    logic                cp0_we;
    logic [4:0]          cp0_waddr;
    logic [31:0]         cp0_wdata;
    logic [4:0]          cp0_raddr;
    logic [31:0]         cp0_rdata;
    logic [HW-1:0]       hw_int;
    logic                flush;
    logic [31:0]         flush_pc;
    logic [LANES-1:0]    kill;
    logic                int_pending;

    always #5 clk = ~clk;

    cp0_nlane #(
        .LANES    (LANES),
        .HW_INT   (HW),
        .EXC_VEC  (VEC),
        .COUNT_DIV(DIV)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .lane_valid_i  (lane_valid),
        .lane_exc_i    (lane_exc),
        .lane_eret_i   (lane_eret),
        .lane_bd_i     (lane_bd),
        .lane_pc_i     (lane_pc),
        .lane_badaddr_i(lane_badaddr),
        .cp0_we_i      (cp0_we),
        .cp0_waddr_i   (cp0_waddr),
        .cp0_wdata_i   (cp0_wdata),
        .cp0_raddr_i   (cp0_raddr),
        .cp0_rdata_o   (cp0_rdata),
        .hw_int_i      (hw_int),
        .flush_o       (flush),
        .flush_pc_o    (flush_pc),
        .kill_o        (kill),
        .int_pending_o (int_pending)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Architectural state of the reference model.
    logic [31:0] m_status, m_epc, m_bva, m_compare, m_cbase;
    logic        m_bd, m_ti, m_pend;
    logic [1:0]  m_ipsw;
    logic [4:0]  m_code;
    logic [5:0]  m_hw;
    longint      m_ticks;

    // ExcCode per flag bit, index 0 = ades ... 6 = adel_if; higher index = higher priority.
    int exc_code_tbl [7] = '{5, 4, 9, 8, 12, 10, 4};

    logic        e_valid, e_exc, e_bd, e_bva_we;
    int          e_lane;
    logic [4:0]  e_code;
    logic [31:0] e_pc, e_bva;

    logic [31:0]      obs_rdata, obs_fpc;
    logic             obs_flush, obs_pend;
    logic [LANES-1:0] obs_kill;

    task automatic model_reset();
        m_status = 32'h0040_0000;
        m_epc = '0; m_bva = '0; m_compare = '0; m_cbase = '0;
        m_bd = 1'b0; m_ti = 1'b0; m_pend = 1'b0;
        m_ipsw = '0; m_code = '0; m_hw = '0; m_ticks = 0;
    endtask

    function automatic logic [31:0] m_count();
        return TIMER ? (m_cbase + 32'(m_ticks / DIV)) : 32'h0;
    endfunction

    function automatic logic [7:0] m_ip();
        return {m_hw[5] | (TIMER & m_ti), m_hw[4:0], m_ipsw};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bva;
            5'd9:    return m_count();
            5'd11:   return TIMER ? m_compare : 32'h0;
            5'd12:   return m_status;
            5'd13:   return {m_bd, TIMER & m_ti, 14'b0, m_ip(), 1'b0, m_code, 2'b00};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_event();
        logic [6:0] f;
        e_valid = 0; e_exc = 0; e_bd = 0; e_bva_we = 0; e_lane = 0;
        e_code = '0; e_pc = '0; e_bva = '0;
        if (m_pend && lane_valid[0]) begin
            e_valid = 1; e_exc = 1; e_bd = lane_bd[0]; e_pc = lane_pc[31:0];
        end else begin
            for (int i = 0; i < LANES; i++) begin
                f = lane_exc[i*7 +: 7];
                if (!e_valid && lane_valid[i] && (f != 0 || lane_eret[i])) begin
                    e_valid = 1; e_exc = (f != 0); e_lane = i;
                    e_bd = lane_bd[i]; e_pc = lane_pc[i*32 +: 32];
                    for (int p = 6; p >= 0; p--) begin
                        if (f[p]) begin
                            e_code   = 5'(exc_code_tbl[p]);
                            e_bva_we = (p == 6) || (p <= 1);
                            e_bva    = (p == 6) ? lane_pc[i*32 +: 32] : lane_badaddr[i*32 +: 32];
                            break;
                        end
                    end
                end
            end
        end
    endtask

    task automatic model_step();
        logic mtc, match, old_exl, n_pend;
        if (rst) begin
            model_reset();
            return;
        end
        old_exl = m_status[1];
        match   = TIMER && (m_count() == m_compare) && (m_compare != 0);
        mtc     = cp0_we && !(e_valid && e_exc && e_lane == 0);
        n_pend  = ((m_ip() & m_status[15:8]) != 0) && m_status[0] && !old_exl &&
                  !(e_valid && e_exc);
        m_hw    = hw_int;
        m_ticks++;
        if (mtc && cp0_waddr == 5'd12) m_status = cp0_wdata | 32'h0040_0000;
        if (mtc && cp0_waddr == 5'd13) m_ipsw = cp0_wdata[9:8];
        if (mtc && cp0_waddr == 5'd14) m_epc = cp0_wdata;
        if (TIMER && mtc && cp0_waddr == 5'd9) begin
            m_cbase = cp0_wdata;
            m_ticks = 0;
        end
        if (TIMER && mtc && cp0_waddr == 5'd11) begin
            m_compare = cp0_wdata;
            m_ti = 0;
        end
        if (match) m_ti = 1;
        if (e_valid && e_exc) begin
            if (!old_exl) begin
                m_epc = e_bd ? e_pc - 32'd4 : e_pc;
                m_bd  = e_bd;
            end
            m_code = e_code;
            if (e_bva_we) m_bva = e_bva;
            m_status[1] = 1'b1;
        end else if (e_valid) begin
            m_status[1] = 1'b0;
        end
        m_pend = n_pend;
    endtask

    // One commit cycle: inputs are already driven; check at the falling edge, then advance.
    task automatic cycle();
        logic [LANES-1:0] ek;
        @(negedge clk);
        model_event();
        ek = '0;
        for (int j = 0; j < LANES; j++) begin
            if (e_valid && (j > e_lane || (j == e_lane && e_exc))) ek[j] = 1'b1;
        end
        obs_rdata = cp0_rdata; obs_fpc = flush_pc; obs_flush = flush;
        obs_pend = int_pending; obs_kill = kill;
        check_eq("flush", flush, e_valid);
        if (e_valid) check_eq("flush_pc", flush_pc, e_exc ? VEC : m_epc);
        check_eq("kill", kill, ek);
        check_eq("int_pending", int_pending, m_pend);
        check_eq("rdata", cp0_rdata, m_read(cp0_raddr));
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lane_valid = '0; lane_exc = '0; lane_eret = '0; lane_bd = '0;
        lane_pc = '0; lane_badaddr = '0;
        cp0_we = 1'b0; cp0_waddr = '0; cp0_wdata = '0; cp0_raddr = '0;
    endtask

    task automatic rd(input logic [4:0] a);
        idle();
        cp0_raddr = a;
        cycle();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle();
        lane_valid = 2'b01;
        cp0_we = 1'b1; cp0_waddr = a; cp0_wdata = d;
        cycle();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    logic [4:0] addr_tbl [7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};

    task automatic rand_inputs();
        logic [6:0] f;
        lane_valid = LANES'($urandom);
        for (int i = 0; i < LANES; i++) begin
            f = '0;
            if ($urandom_range(0, 5) == 0) begin
                f = 7'(1 << $urandom_range(0, 6));
                if ($urandom_range(0, 3) == 0) f = f | 7'($urandom);
            end
            lane_exc[i*7 +: 7]      = f;
            lane_eret[i]            = ($urandom_range(0, 9) == 0);
            lane_bd[i]              = 1'($urandom);
            lane_pc[i*32 +: 32]     = $urandom & 32'hFFFF_FFFC;
            lane_badaddr[i*32 +: 32] = $urandom;
        end
        cp0_we    = ($urandom_range(0, 3) == 0);
        cp0_waddr = addr_tbl[$urandom_range(0, 6)];
        case ($urandom_range(0, 7))
            0, 1:    cp0_wdata = $urandom_range(0, 15);
            2:       cp0_wdata = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            default: cp0_wdata = $urandom;
        endcase
        cp0_raddr = addr_tbl[$urandom_range(0, 6)];
        if ($urandom_range(0, 7) == 0) hw_int = HW'($urandom);
        rst = ($urandom_range(0, 399) == 0);
    endtask

    initial begin
        idle();
        hw_int = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;

        rd(5'd12);
        check_eq("rst_status", obs_rdata, 32'h0040_0000);
        check_eq("rst_flush", obs_flush, 1'b0);
        check_eq("rst_kill", obs_kill, 2'b00);
        check_eq("rst_pend", obs_pend, 1'b0);

        // Oldest lane wins: lane 0 overflow beats lane 1 syscall.
        idle();
        lane_valid = 2'b11; lane_exc[4] = 1'b1; lane_exc[7+3] = 1'b1;
        lane_pc[31:0] = 32'h8000_0100;
        cycle();
        check_eq("sel_flush", obs_flush, 1'b1);
        check_eq("sel_pc", obs_fpc, VEC);
        check_eq("sel_kill", obs_kill, 2'b11);
        rd(5'd14);
        check_eq("sel_epc", obs_rdata, 32'h8000_0100);
        rd(5'd13);
        check_eq("sel_code", obs_rdata[6:2], 5'd12);
        rd(5'd12);
        check_eq("sel_exl", obs_rdata[1], 1'b1);

        // ERET returns to EPC and clears EXL.
        mtc0(5'd14, 32'h8000_0300);
        idle();
        lane_valid = 2'b11; lane_eret[0] = 1'b1;
        cycle();
        check_eq("eret_flush", obs_flush, 1'b1);
        check_eq("eret_pc", obs_fpc, 32'h8000_0300);
        check_eq("eret_kill", obs_kill, 2'b10);
        rd(5'd12);
        check_eq("eret_exl", obs_rdata[1], 1'b0);

        // Delay-slot fetch error on lane 1.
        idle();
        lane_valid = 2'b11; lane_exc[7+6] = 1'b1; lane_bd[1] = 1'b1;
        lane_pc[63:32] = 32'h8000_0204;
        cycle();
        check_eq("ds_kill", obs_kill, 2'b10);
        rd(5'd14);
        check_eq("ds_epc", obs_rdata, 32'h8000_0200);
        rd(5'd13);
        check_eq("ds_bd", obs_rdata[31], 1'b1);
        rd(5'd8);
        check_eq("ds_bva", obs_rdata, 32'h8000_0204);

        // Hardware interrupt latency and delivery on lane 0.
        mtc0(5'd12, 32'h0040_0401);
        idle();
        hw_int[0] = 1'b1;
        cycle();
        check_eq("int_t0", obs_pend, 1'b0);
        cycle();
        check_eq("int_t1", obs_pend, 1'b0);
        cycle();
        check_eq("int_t2", obs_pend, 1'b1);
        idle();
        lane_valid = 2'b01;
        cycle();
        check_eq("int_flush", obs_flush, 1'b1);
        check_eq("int_pc", obs_fpc, VEC);
        check_eq("int_kill", obs_kill, 2'b11);
        hw_int = '0;
        rd(5'd13);
        check_eq("int_code", obs_rdata[6:2], 5'd0);

        // MTC0 Status from the excepting lane 0 is dropped.
        do_reset();
        idle();
        lane_valid = 2'b01; lane_exc[5] = 1'b1;
        cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'h0;
        cycle();
        rd(5'd12);
        check_eq("smtc_status", obs_rdata, 32'h0040_0002);

`ifdef CP0_TIMER_EN
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        for (int n = 0; n <= 12; n++) begin
            rd(5'd13);
            if (n == 9) check_eq("tm_ti_early", obs_rdata[30], 1'b0);
            if (n == 12) check_eq("tm_ti_set", obs_rdata[30], 1'b1);
        end
        mtc0(5'd11, 32'd100);
        rd(5'd13);
        check_eq("tm_ti_clr", obs_rdata[30], 1'b0);
`endif

        for (int n = 0; n < 4000; n++) begin
            rand_inputs();
            cycle();
        end

        // Reset in the middle of traffic.
        hw_int = '0;
        do_reset();
        rd(5'd12);
        check_eq("rst2_status", obs_rdata, 32'h0040_0000);
        check_eq("rst2_flush", obs_flush, 1'b0);
        check_eq("rst2_kill", obs_kill, 2'b00);
        check_eq("rst2_pend", obs_pend, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cp0_nlane.md
# cp0_nlane

Parametrised coprocessor-0 block for the N-issue MIPS pipeline. It sits at the commit stage. Each cycle it takes the exception, ERET and CP0-access information of up to `LANES` committing instructions and selects the oldest event. It keeps BadVAddr, Count, Compare, Status, Cause and EPC, samples hardware interrupts, and drives the pipeline flush, the redirect PC and the kill mask for younger lanes.

## Interface
- `LANES`, 2: committing lanes; lane 0 is the oldest.
- `HW_INT`, 6: hardware interrupt lines (1..6), mapped to Cause.IP[2+i].
- `EXC_VEC`, 32'hBFC0_0380: exception entry PC.
- `COUNT_DIV`, 2: Count increments once every `COUNT_DIV` clk cycles (≥1).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `lane_valid`  in  LANES  lane holds a committing instruction.
- `lane_exc`  in  LANES*7  per-lane flags {adel_if, ri, ov, sys, bp, adel, ades}.
- `lane_eret`  in  LANES  ERET commits.
- `lane_bd`  in  LANES  instruction is in a delay slot.
- `lane_pc`  in  LANES*32  instruction PC.
- `lane_badaddr`  in  LANES*32  faulting data address.
- `cp0_we`, `cp0_waddr[4:0]`, `cp0_wdata[31:0]`  in  MTC0 write port, owned by lane 0. The decoder guarantees that only lane 0 issues MTC0/MFC0.
- `cp0_raddr`  in  5  MFC0 address.
- `cp0_rdata`  out  32  read data, combinational. Unimplemented registers read 0.
- `hw_int`  in  HW_INT  level interrupt requests.
- `flush`  out  1  redirect the pipeline (combinational, same cycle).
- `flush_pc`  out  32  redirect target.
- `kill`  out  LANES  lanes whose commit must be suppressed.
- `int_pending`  out  1  registered interrupt request.

## Operation
- **Reset values.**
  - Status = 32'h0040_0000 (BEV=1); all other registers 0.
  - `int_pending`, `flush` and `kill` are 0.
  - The Count prescaler is 0.
- **Event selection.** The winning lane is the lowest index `i` with `lane_valid[i]` and (any `lane_exc` bit or `lane_eret`).
  - If `int_pending`=1 and `lane_valid[0]`=1, the interrupt attaches to lane 0 and outranks everything else.
- **Per-lane priority** (ExcCode in brackets): interrupt(0) > adel_if(4, BadVAddr=PC) > ri(10) > ov(12) > sys(8) > bp(9) > adel(4, BadVAddr=badaddr) > ades(5, BadVAddr=badaddr) > eret.
- **Exception taken.** At the next edge:
  - EPC = bd ? pc−4 : pc.
  - Cause.BD = bd; Cause.ExcCode as above.
  - Status.EXL = 1.
  - `flush_pc` = `EXC_VEC`.
  - If EXL is already 1, EPC and Cause.BD are not updated. ExcCode and BadVAddr still update.
- **ERET taken.** Status.EXL ← 0; `flush_pc` = EPC (current value).
- **Kill mask.** `kill[j]` = 1 for all j > winner. The winner itself is killed for exceptions and not for ERET.
- **MTC0 and writable fields.** MTC0 applies only when `cp0_we` and lane 0 is not the winning exception lane.
  - Status: BEV is forced to 1.
  - Cause: only IP[1:0] is writable.
  - Compare: the write also clears Cause.TI.
- **Same-cycle write priority.** When MTC0 and a hardware update hit the same register field in one cycle, the hardware update wins.
- **Interrupt inputs.**
  - Cause.IP[7:2] ← registered `hw_int`. Under the timer feature, IP7 is ORed with TI.
  - `int_pending` ← (Cause.IP & Status.IM) ≠ 0 && Status.IE && !EXL, registered.

## Timing
- `flush`, `flush_pc`, `kill` and `cp0_rdata` are combinational in the commit cycle. Register updates land at the following edge.
- Interrupt latency:
  - `hw_int` rising to Cause.IP visible: 1 cycle.
  - `hw_int` rising to `int_pending`: 2 cycles.
  - The interrupt is taken at the first later cycle with `lane_valid[0]`.
- A read at the same address as a same-cycle write returns the old value.
- **Count.** Wraps from 32'hFFFF_FFFF to 0.
  - A Count write reloads Count and resets the prescaler.
  - TI is set in the cycle Count == Compare and Compare ≠ 0. It stays set until Compare is written.
- `rst` asserted mid-operation returns all state to reset values at that edge, including the prescaler and the `hw_int` sample register.

## Configuration
- `CP0_TIMER_EN` defined:
  - Count, Compare and TI are implemented as above.
  - Cause.IP7 = `hw_int[5]` | TI.
- `CP0_TIMER_EN` undefined:
  - Count and Compare read 0; writes to them are ignored.
  - TI stays 0.
  - Cause.IP7 = `hw_int[5]` only.
  - No prescaler logic is built.

## Test plan
- **Lane selection.** LANES=2: lane0 ov=1, lane1 sys=1, pc0=32'h8000_0100, bd0=0 → flush=1, flush_pc=32'hBFC0_0380, kill=2'b11; next cycle EPC=32'h8000_0100, ExcCode=12, EXL=1.
- **Delay slot.** Lane1-only adel_if with pc1=32'h8000_0204, bd1=1 → kill=2'b10; EPC=32'h8000_0200, Cause.BD=1, BadVAddr=32'h8000_0204.
- **ERET.** EXL=1, EPC=32'h8000_0300: lane0 eret → flush_pc=32'h8000_0300, kill=2'b10; EXL=0 next cycle.
- **Hardware interrupt.** Status=32'h0040_0401 (IM2, IE=1), hw_int[0]=1 at cycle t → int_pending=1 at t+2; first valid lane0 commit gives ExcCode=0, flush=1.
- **Timer.** With `CP0_TIMER_EN`: write Compare=5, then Count=0 → TI=1 after 10 cycles (COUNT_DIV=2). A Compare write clears TI.
- **Suppressed MTC0 and reset.** MTC0 Status=0 coincident with lane0 ri → Status unchanged except EXL=1. Assert rst mid-stream → Status=32'h0040_0000, all outputs 0.
